inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Write-side counterpart of the byte-addressed, big-endian instruction memory.
//  - Accepts 32-bit instruction words over a valid/ready handshake.
//  - Splits each word into 4 bytes, MSB first, one byte write per cycle on the
//    memory's byte write port, at consecutive addresses.
//  - Used by the bench/boot path to load a program before the CPU starts fetching.
// PARAMETERS
//  MEM_BYTES  128  memory size in bytes; legal byte addresses are 0..MEM_BYTES-1
//  BASE_ADDR  0    first byte address written after start; multiple of 4, < MEM_BYTES
//  CNT_W      6    width of wordCount; must hold MEM_BYTES/4
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  start      in   1      level sampled each edge; (re)arms loader; pointer -> BASE_ADDR
//  wordValid  in   1      wordIn/last are valid
//  wordIn     in   32     instruction word
//  last       in   1      qualifies wordIn; marks final word of the program
//  wordReady  out  1      loader can accept a word this cycle
//  memWe      out  1      byte write enable
//  memAddr    out  32     byte write address
//  memData    out  8      byte write data
//  busy       out  1      state is ACCEPT or WRITE
//  done       out  1      load finished; sticky until start or reset
//  overflow   out  1      memory filled before a last word; sticky until start or reset
//  wordCount  out  CNT_W  number of words fully written since start
// BEHAVIOUR
//  - States: IDLE, ACCEPT, WRITE (byte index 0..3), DONE.
//  - Reset (rst_n=0 at an edge; overrides everything): state=IDLE, ptr=BASE_ADDR.
//    All outputs are 0: wordReady, memWe, memAddr, memData, busy, done,
//    overflow, wordCount.
//  - start=1 at an edge, any state except under reset:
//    -> state=ACCEPT, ptr=BASE_ADDR, wordCount=0, done=0, overflow=0.
//    -> Any unwritten bytes of the current word are dropped.
//    -> start has priority over a handshake in the same cycle; that word is not accepted.
//  - Outputs are decoded from registered state only; none is combinational from inputs.
//  - wordReady=1 only in ACCEPT.
//  - A transfer occurs at an edge where wordValid=1, wordReady=1 and start=0:
//    -> latch wordIn and last; go to WRITE with byte index 0.
//  - WRITE byte index b=0..3:
//    -> memWe=1, memAddr=ptr+b, memData=word[31-8b -: 8] (b=0 gives [31:24]).
//  - After b=3: ptr+=4, wordCount+=1. Next state:
//    -> latched last=1: DONE, done=1 (last has priority if both conditions hold).
//    -> else ptr+4 == MEM_BYTES: DONE, done=1, overflow=1.
//    -> else: ACCEPT.
//  - Latency/throughput:
//    -> handshake at edge k; bytes driven in cycles k+1..k+4; wordReady=1 again in cycle k+5.
//    -> Throughput 1 word per 5 cycles; no buffering beyond one word.
//  - Outside WRITE: memWe=0; memAddr and memData hold their last driven values (0 after reset).
//  - IDLE and DONE: wordValid is ignored, wordReady=0, nothing is written.
//    Exit only via start or reset.
//  - Address never reaches MEM_BYTES: ptr range is BASE_ADDR..MEM_BYTES-4 while writing.
//  - wordIn and last may change freely while wordReady=0.
// TESTING
//  1. Reset, start, words 0x00500093 (last=0) then 0x00A00113 (last=1)
//     -> bytes 0..7 = 00 50 00 93 00 A0 01 13.
//     -> done=1, wordCount=2, overflow=0.
//  2. 32 words, all last=0
//     -> 128 byte writes, done=1, overflow=1, wordCount=32.
//     -> A 33rd word held valid is never accepted; memWe stays 0.
//  3. wordValid toggles, with gaps in ACCEPT and assertions during WRITE
//     -> memWe only in the 4 cycles after each handshake.
//     -> No word lost or duplicated; wordReady=0 throughout WRITE.
//  4. start asserted while writing byte 1 of word 0xDEADBEEF
//     -> DE and AD written, BE and EF never written.
//     -> Next word lands at addr BASE_ADDR; wordCount=0.
//  5. rst_n=0 mid-WRITE
//     -> next cycle all outputs 0, state IDLE.
//     -> Words ignored until start; load then begins at BASE_ADDR.
//  6. BASE_ADDR=16, words all last=0
//     -> first write at addr 16; overflow after 28 words, last write at addr 127.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Boot-path loader: takes 32-bit instruction words over valid/ready and writes
// them big-endian, one byte per cycle, into a byte-addressed instruction memory.
module inst_mem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wordValid,
  input  logic [31:0]      wordIn,
  input  logic             last,
  output logic             wordReady,
  output logic             memWe,
  output logic [31:0]      memAddr,
  output logic [7:0]       memData,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] wordCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] BASE_PTR = 32'(BASE_ADDR);
  localparam logic [31:0] LAST_PTR = 32'(MEM_BYTES - 4);

  state_t      state_r;
  logic [31:0] ptr_r;
  logic [31:0] word_r;
  logic        last_r;
  logic [1:0]  idx_r;

  // Byte b of a big-endian word: b=0 is the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] b);
    logic [7:0] r;
    case (b)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      2'd3:    r = w[7:0];
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= BASE_PTR;
      word_r    <= 32'd0;
      last_r    <= 1'b0;
      idx_r     <= 2'd0;
      wordReady <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= 32'd0;
      memData   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      wordCount <= '0;
    end else if (start) begin
      // Re-arm from any state; a word in flight is abandoned.
      state_r   <= ACCEPT;
      ptr_r     <= BASE_PTR;
      idx_r     <= 2'd0;
      wordReady <= 1'b1;
      memWe     <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      overflow  <= 1'b0;
      wordCount <= '0;
    end else begin
      case (state_r)
        ACCEPT: begin
          if (wordValid) begin
            word_r    <= wordIn;
            last_r    <= last;
            idx_r     <= 2'd0;
            state_r   <= WRITE;
            wordReady <= 1'b0;
            memWe     <= 1'b1;
            memAddr   <= ptr_r;
            memData   <= wordIn[31:24];
          end else begin
            wordReady <= 1'b1;
            memWe     <= 1'b0;
          end
        end
        WRITE: begin
          if (idx_r == 2'd3) begin
            memWe     <= 1'b0;
            ptr_r     <= ptr_r + 32'd4;
            wordCount <= wordCount + CNT_W'(1);
            // A last word wins over the memory-full condition.
            if (last_r) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (ptr_r == LAST_PTR) begin
              state_r  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              overflow <= 1'b1;
            end else begin
              state_r   <= ACCEPT;
              wordReady <= 1'b1;
            end
          end else begin
            idx_r   <= idx_r + 2'd1;
            memWe   <= 1'b1;
            memAddr <= ptr_r + {30'd0, idx_r + 2'd1};
            memData <= byte_sel(word_r, idx_r + 2'd1);
          end
        end
        IDLE, DONE: begin
          wordReady <= 1'b0;
          memWe     <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          wordReady <= 1'b0;
          memWe     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: byte writes are scoreboarded against a
// queue filled at each handshake; two instances cover BASE_ADDR 0 and 16.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, word_valid, last_in;
  logic [31:0] word_in;

  logic        ready0, we0, busy0, done0, ovf0;
  logic [31:0] addr0;
  logic [7:0]  data0;
  logic [5:0]  cnt0;
  logic        ready16, we16, busy16, done16, ovf16;
  logic [31:0] addr16;
  logic [7:0]  data16;
  logic [5:0]  cnt16;

  int tests = 0;
  int fails = 0;

  logic        mon_sel;
  logic        we_m, rdy_m;
  logic [31:0] addr_m;
  logic [7:0]  data_m;
  logic [31:0] exp_ptr;
  logic [31:0] last_addr;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  always #5 clk = ~clk;

  inst_mem_loader #(.MEM_BYTES(128), .BASE_ADDR(0), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wordValid(word_valid),
    .wordIn(word_in), .last(last_in), .wordReady(ready0), .memWe(we0),
    .memAddr(addr0), .memData(data0), .busy(busy0), .done(done0),
    .overflow(ovf0), .wordCount(cnt0)
  );

  inst_mem_loader #(.MEM_BYTES(128), .BASE_ADDR(16), .CNT_W(6)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .wordValid(word_valid),
    .wordIn(word_in), .last(last_in), .wordReady(ready16), .memWe(we16),
    .memAddr(addr16), .memData(data16), .busy(busy16), .done(done16),
    .overflow(ovf16), .wordCount(cnt16)
  );

  assign we_m   = mon_sel ? we16   : we0;
  assign rdy_m  = mon_sel ? ready16 : ready0;
  assign addr_m = mon_sel ? addr16 : addr0;
  assign data_m = mon_sel ? data16 : data0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard compare of the byte write port of the selected instance.
  task automatic mon_check();
    logic [31:0] ea;
    logic [7:0]  ed;
    if (we_m === 1'b1) begin
      tests++;
      assert (exp_addr_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_write: got write addr=%0h data=%0h expected no write", addr_m, data_m);
      end
      if (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("byte_addr", addr_m, ea);
        check("byte_data", {24'd0, data_m}, {24'd0, ed});
        last_addr = addr_m;
      end
      check("ready_in_write", {31'd0, rdy_m}, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_check();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      exp_addr_q.push_back(exp_ptr + 32'(b));
      exp_data_q.push_back(8'((w >> (24 - 8 * b)) & 32'hFF));
    end
    exp_ptr = exp_ptr + 32'd4;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    logic got;
    got        = 1'b0;
    word_valid = 1'b1;
    word_in    = w;
    last_in    = l;
    for (int i = 0; i < 60 && !got; i++) begin
      if (rdy_m === 1'b1) begin
        push_word(w);
        got = 1'b1;
      end
      tick();
    end
    word_valid = 1'b0;
    check("handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] pat;
    int n;
    rst_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_in = 32'd0; last_in = 1'b0;
    mon_sel = 1'b0; exp_ptr = 32'd0; last_addr = 32'd0;
    #1;
    wait_cycles(2);

    // Reset state
    check("rst_ready", {31'd0, ready0}, 32'd0);
    check("rst_we", {31'd0, we0}, 32'd0);
    check("rst_addr", addr0, 32'd0);
    check("rst_data", {24'd0, data0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_ovf", {31'd0, ovf0}, 32'd0);
    check("rst_cnt", {26'd0, cnt0}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // 1: two-word program
    do_start();
    check("t1_ready", {31'd0, ready0}, 32'd1);
    check("t1_busy", {31'd0, busy0}, 32'd1);
    exp_ptr = 32'd0;
    send_word(32'h0050_0093, 1'b0);
    send_word(32'h00A0_0113, 1'b1);
    wait_cycles(6);
    check("t1_done", {31'd0, done0}, 32'd1);
    check("t1_cnt", {26'd0, cnt0}, 32'd2);
    check("t1_ovf", {31'd0, ovf0}, 32'd0);
    check("t1_busy_end", {31'd0, busy0}, 32'd0);
    check("t1_ready_end", {31'd0, ready0}, 32'd0);

    // 2: fill memory, then a 33rd word must be refused
    do_start();
    exp_ptr = 32'd0;
    for (int i = 0; i < 32; i++) send_word(32'h1000_0001 + 32'(i) * 32'h0103_0507, 1'b0);
    wait_cycles(6);
    check("t2_done", {31'd0, done0}, 32'd1);
    check("t2_ovf", {31'd0, ovf0}, 32'd1);
    check("t2_cnt", {26'd0, cnt0}, 32'd32);
    check("t2_last_addr", last_addr, 32'd127);
    word_valid = 1'b1; word_in = 32'hFFFF_FFFF;
    wait_cycles(20);
    check("t2_ready_after", {31'd0, ready0}, 32'd0);
    word_valid = 1'b0;

    // 3: gappy wordValid, also asserted during WRITE
    do_start();
    exp_ptr = 32'd0;
    pat = 8'b1011_0010;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      word_valid = pat[c % 8];
      word_in    = 32'hC0DE_0000 + 32'(c);
      last_in    = 1'b0;
      if (word_valid && rdy_m === 1'b1) begin
        push_word(word_in);
        n++;
      end
      tick();
    end
    word_valid = 1'b0;
    wait_cycles(6);
    check("t3_words", 32'(n), 32'd6);
    check("t3_cnt", {26'd0, cnt0}, 32'd6);
    check("t3_ready", {31'd0, ready0}, 32'd1);

    // 4: restart while byte 1 of 0xDEADBEEF is being written
    word_valid = 1'b1; word_in = 32'hDEAD_BEEF; last_in = 1'b0;
    exp_addr_q.push_back(exp_ptr);          exp_data_q.push_back(8'hDE);
    exp_addr_q.push_back(exp_ptr + 32'd1);  exp_data_q.push_back(8'hAD);
    tick();
    word_valid = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_cnt", {26'd0, cnt0}, 32'd0);
    check("t4_ready", {31'd0, ready0}, 32'd1);
    exp_ptr = 32'd0;
    send_word(32'h1234_5678, 1'b1);
    wait_cycles(6);
    check("t4_done", {31'd0, done0}, 32'd1);
    check("t4_cnt_end", {26'd0, cnt0}, 32'd1);

    // 5: reset in the middle of a word
    do_start();
    exp_ptr = 32'd0;
    word_valid = 1'b1; word_in = 32'hAABB_CCDD; last_in = 1'b0;
    exp_addr_q.push_back(32'd0); exp_data_q.push_back(8'hAA);
    exp_addr_q.push_back(32'd1); exp_data_q.push_back(8'hBB);
    tick();
    word_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_we", {31'd0, we0}, 32'd0);
    check("t5_addr", addr0, 32'd0);
    check("t5_data", {24'd0, data0}, 32'd0);
    check("t5_busy", {31'd0, busy0}, 32'd0);
    check("t5_ready", {31'd0, ready0}, 32'd0);
    check("t5_cnt", {26'd0, cnt0}, 32'd0);
    rst_n = 1'b1;
    word_valid = 1'b1; word_in = 32'h5555_AAAA;
    wait_cycles(10);
    check("t5_idle_ready", {31'd0, ready0}, 32'd0);
    word_valid = 1'b0;
    do_start();
    exp_ptr = 32'd0;
    send_word(32'h1122_3344, 1'b1);
    wait_cycles(6);
    check("t5_done", {31'd0, done0}, 32'd1);
    check("t5_cnt_end", {26'd0, cnt0}, 32'd1);

    // 6: BASE_ADDR=16 instance overflows after 28 words
    mon_sel = 1'b1;
    do_start();
    exp_ptr = 32'd16;
    for (int i = 0; i < 28; i++) send_word(32'hA500_0000 + 32'(i), 1'b0);
    wait_cycles(6);
    check("t6_done", {31'd0, done16}, 32'd1);
    check("t6_ovf", {31'd0, ovf16}, 32'd1);
    check("t6_cnt", {26'd0, cnt16}, 32'd28);
    check("t6_last_addr", last_addr, 32'd127);
    check("t6_ready", {31'd0, ready16}, 32'd0);

    check("sb_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
